demosaic_neighbor_stream: RTL and testbench
===========================================

# demosaic_neighbor_stream

Parametrised 2x2 nearest-neighbour Bayer demosaic for the camera front end. Accepts one raw Bayer sample per qualified cycle in raster order, keeps one internal row line buffer, and emits one RGB pixel per completed 2x2 window with frame/line markers. Sits between the sensor capture block and the colour-correction/output stages. Generalises the fixed 8-bit RGGB neighbour demosaic with configurable width, frame size, run-time Bayer phase, gap-tolerant input and explicit frame resync.

## Interface
- DATA_WIDTH, 8, bits per raw sample and per output colour channel
- WIDTH, 320, input frame width in pixels (>= 2)
- HEIGHT, 240, input frame height in rows (>= 2)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- iData  in  DATA_WIDTH  raw Bayer sample
- iValid  in  1  iData qualifier; no backpressure
- iSof  in  1  start of frame; meaningful only with iValid
- iPattern  in  2  Bayer phase: 00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR
- oR, oG, oB  out  DATA_WIDTH each  output colour channels
- oValid  out  1  output qualifier
- oSof  out  1  with first output pixel of a frame
- oEol  out  1  with last output pixel of each output row
- oEof  out  1  with last output pixel of a frame

## Operation
- Input counters x (0..WIDTH-1), y (0..HEIGHT-1) advance only on iValid; x wraps to 0 and increments y; after (WIDTH-1,HEIGHT-1) both wrap to 0.
- iValid with iSof: sample treated as (0,0) regardless of counters; counters continue from (1,0). iSof without iValid ignored.
- iPattern latched into an internal phase register on every accepted (0,0) sample; held for the whole frame. iPattern = {pr,pc}: R sits at row parity pr, column parity pc.
- Line buffer: WIDTH entries x DATA_WIDTH, addressed by x; on each accepted sample, returns the previous row's value at x, then stores iData. Contents not cleared by reset.
- Window for accepted sample (x,y), x>=1 and y>=1: previous row cols x-1, x; current row cols x-1, x. Top-left absolute coordinate (x-1,y-1). Samples with x=0 or y=0 produce no output. Output frame is (WIDTH-1) x (HEIGHT-1).
- Colour selection by absolute parity: R = window position with row parity pr and col parity pc; B = position with row parity !pr, col parity !pc; G1, G2 = other two.
- oG = (G1+G2)>>1, sum computed at DATA_WIDTH+1 bits, result never overflows.
- oSof on output of window (1,1); oEol when x = WIDTH-1; oEof on window (WIDTH-1,HEIGHT-1).

## Timing
- Fixed latency: sample accepted on edge n -> oValid and data registered on edge n+2. Pipeline advances every cycle; iValid gaps only produce oValid gaps, never change latency.
- oValid high one cycle per output; no hold when idle.
- Reset (async assert): oR, oG, oB = 0, oValid/oSof/oEol/oEof = 0, x = y = 0, phase register = 00, pipeline valids cleared. Deassert mid-frame: next accepted sample is (0,0).
- iSof arriving mid-frame: in-flight outputs already in the pipeline still complete; no oEof for the aborted frame; next output frame starts with oSof.
- Back-to-back frames with no gap: row 0 of new frame uses new phase; no bubble needed.
- oR/oB/oG hold last value while oValid low.

## Configuration
- DEMOSAIC_ROUND_EN defined: oG = (G1+G2+1)>>1 (round half up). Undefined: oG = (G1+G2)>>1 (truncate). No other behaviour changes.

## Test plan
- Reset: assert reset=0 mid-stream -> all outputs 0 within same cycle, first post-reset sample treated as (0,0).
- WIDTH=4, HEIGHT=3, DW=8, RGGB, iData = raster index 0..11, continuous iValid -> 6 outputs; first (oSof) R=0, G=2 (3 with DEMOSAIC_ROUND_EN), B=5, 2 cycles after sample 5; oEol on 3rd and 6th; oEof on 6th.
- Same stimulus, iPattern=11 (BGGR) -> first output R=5, G=2, B=0; iPattern=01 -> R=1, G=2, B=4.
- Same stimulus with random iValid gaps -> identical output sequence, each oValid exactly 2 cycles after its triggering sample.
- iSof asserted on sample 7 of a frame -> counters resync, next 12 samples produce a full 6-pixel frame with oSof/oEof, no oEof for aborted frame.
- DATA_WIDTH=10, all samples 1023 -> oR=oG=oB=1023 with and without DEMOSAIC_ROUND_EN.

Source files
------------

// File: rtl/demosaic_neighbor_stream.sv
// demosaic_neighbor_stream
//
// 2x2 nearest-neighbour Bayer demosaic over a raster-order sample stream.
// A single row line buffer supplies the previous row. Each accepted sample
// at (x,y) with x>=1 and y>=1 closes a 2x2 window whose top-left corner is
// (x-1,y-1). That window yields one RGB pixel, so the output frame is
// (WIDTH-1) x (HEIGHT-1).
//
// Latency is fixed: a sample accepted on edge n produces its output on
// edge n+2. Input gaps only create output gaps.
//
// Parameters:
//   DATA_WIDTH  bits per raw sample and per output colour channel
//   WIDTH       input frame width in pixels  (>= 2)
//   HEIGHT      input frame height in rows   (>= 2)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   iData      raw Bayer sample
//   iValid     iData qualifier (no backpressure)
//   iSof       start of frame, only meaningful with iValid
//   iPattern   Bayer phase {pr,pc}: 00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR
//   oR/oG/oB   output colour channels; they hold while oValid is low
//   oValid     output qualifier, one cycle per pixel
//   oSof       first pixel of an output frame
//   oEol       last pixel of an output row
//   oEof       last pixel of an output frame
//
// Optional build macro:
//   DEMOSAIC_ROUND_EN  when defined, green = (G1+G2+1)>>1 (round half up);
//                      otherwise green = (G1+G2)>>1 (truncate).

module demosaic_neighbor_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iValid,
    input  logic                  iSof,
    input  logic [1:0]            iPattern,
    output logic [DATA_WIDTH-1:0] oR,
    output logic [DATA_WIDTH-1:0] oG,
    output logic [DATA_WIDTH-1:0] oB,
    output logic                  oValid,
    output logic                  oSof,
    output logic                  oEol,
    output logic                  oEof
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    // ------------------------------------------------------------------
    // Input position tracking and Bayer phase capture
    // ------------------------------------------------------------------
    logic [XW-1:0] x_q, x_d, x_eff;
    logic [YW-1:0] y_q, y_d, y_eff;
    logic [1:0]    phase_q, phase_d;
    logic          at_origin;

    always_comb begin
        // A qualified iSof forces the current sample to (0,0).
        x_eff     = iSof ? '0 : x_q;
        y_eff     = iSof ? '0 : y_q;
        at_origin = (x_eff == '0) && (y_eff == '0);

        x_d     = x_q;
        y_d     = y_q;
        phase_d = phase_q;

        if (iValid) begin
            if (x_eff == X_LAST) begin
                x_d = '0;
                y_d = (y_eff == Y_LAST) ? '0 : y_eff + 1'b1;
            end else begin
                x_d = x_eff + 1'b1;
                y_d = y_eff;
            end
            if (at_origin) begin
                phase_d = iPattern;
            end
        end
    end

    // ------------------------------------------------------------------
    // Row line buffer: read-before-write at column x. Not reset; every
    // location is written during row 0 before any window reads it.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] line_mem [0:WIDTH-1];
    logic [DATA_WIDTH-1:0] lb_rd_q;

    always_ff @(posedge clk) begin
        if (iValid) begin
            lb_rd_q         <= line_mem[x_eff];
            line_mem[x_eff] <= iData;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: captured sample and its position attributes
    // ------------------------------------------------------------------
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_cur_q, s1_cur_d;
    logic                  s1_emit_q, s1_emit_d;
    logic                  s1_xodd_q, s1_xodd_d;
    logic                  s1_yodd_q, s1_yodd_d;
    logic                  s1_sof_q, s1_sof_d;
    logic                  s1_eol_q, s1_eol_d;
    logic                  s1_eof_q, s1_eof_d;
    logic [1:0]            s1_phase_q, s1_phase_d;

    always_comb begin
        s1_valid_d = iValid;
        s1_cur_d   = iValid ? iData : s1_cur_q;
        s1_emit_d  = (x_eff != '0) && (y_eff != '0);
        s1_xodd_d  = x_eff[0];
        s1_yodd_d  = y_eff[0];
        s1_sof_d   = (x_eff == X_ONE) && (y_eff == Y_ONE);
        s1_eol_d   = (x_eff == X_LAST);
        s1_eof_d   = (x_eff == X_LAST) && (y_eff == Y_LAST);
        // The phase travels with the sample so windows still in flight at a
        // frame boundary keep the old frame's phase.
        s1_phase_d = phase_d;
    end

    // Left column of the window: top/bottom values of the previous sample.
    logic [DATA_WIDTH-1:0] left_top_q, left_top_d;
    logic [DATA_WIDTH-1:0] left_bot_q, left_bot_d;

    always_comb begin
        left_top_d = left_top_q;
        left_bot_d = left_bot_q;
        if (s1_valid_q) begin
            left_top_d = lb_rd_q;
            left_bot_d = s1_cur_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour-site selection by absolute parity
    // ------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] pick(
        input logic [1:0]            pos,
        input logic [DATA_WIDTH-1:0] w00,
        input logic [DATA_WIDTH-1:0] w01,
        input logic [DATA_WIDTH-1:0] w10,
        input logic [DATA_WIDTH-1:0] w11
    );
        logic [DATA_WIDTH-1:0] val;
        case (pos)
            2'b00:   val = w00;
            2'b01:   val = w01;
            2'b10:   val = w10;
            default: val = w11;
        endcase
        return val;
    endfunction

    logic [1:0]            r_pos;
    logic                  tl_row_odd;
    logic                  tl_col_odd;
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] s2_r_q, s2_r_d;
    logic [DATA_WIDTH-1:0] s2_b_q, s2_b_d;
    logic [DATA_WIDTH-1:0] s2_g1_q, s2_g1_d;
    logic [DATA_WIDTH-1:0] s2_g2_q, s2_g2_d;
    logic                  s2_sof_q, s2_sof_d;
    logic                  s2_eol_q, s2_eol_d;
    logic                  s2_eof_q, s2_eof_d;

    always_comb begin
        // Window top-left sits at (x-1,y-1), so its parities are inverted.
        // R lands at the window offset that brings the absolute parity to
        // the latched {pr,pc}. B is diagonal to R, and the Gs take the rest.
        tl_row_odd = ~s1_yodd_q;
        tl_col_odd = ~s1_xodd_q;
        r_pos      = {s1_phase_q[1] ^ tl_row_odd, s1_phase_q[0] ^ tl_col_odd};

        s2_valid_d = s1_valid_q && s1_emit_q;
        s2_sof_d   = s2_valid_d && s1_sof_q;
        s2_eol_d   = s2_valid_d && s1_eol_q;
        s2_eof_d   = s2_valid_d && s1_eof_q;

        s2_r_d  = s2_r_q;
        s2_b_d  = s2_b_q;
        s2_g1_d = s2_g1_q;
        s2_g2_d = s2_g2_q;
        if (s2_valid_d) begin
            s2_r_d  = pick(r_pos, left_top_q, lb_rd_q, left_bot_q, s1_cur_q);
            s2_b_d  = pick(~r_pos, left_top_q, lb_rd_q, left_bot_q, s1_cur_q);
            s2_g1_d = pick({r_pos[1], ~r_pos[0]}, left_top_q, lb_rd_q, left_bot_q, s1_cur_q);
            s2_g2_d = pick({~r_pos[1], r_pos[0]}, left_top_q, lb_rd_q, left_bot_q, s1_cur_q);
        end
    end

    // ------------------------------------------------------------------
    // Output stage: green average and registered outputs
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]   g_sum;
    logic [DATA_WIDTH-1:0] g_avg;

    always_comb begin
`ifdef DEMOSAIC_ROUND_EN
        g_sum = {1'b0, s2_g1_q} + {1'b0, s2_g2_q} + {{DATA_WIDTH{1'b0}}, 1'b1};
`else
        g_sum = {1'b0, s2_g1_q} + {1'b0, s2_g2_q};
`endif
        // The sum is at most 2^(DATA_WIDTH+1)-1, so the halved value always fits.
        g_avg = DATA_WIDTH'(g_sum >> 1);
    end

    logic [DATA_WIDTH-1:0] out_r_q, out_r_d;
    logic [DATA_WIDTH-1:0] out_g_q, out_g_d;
    logic [DATA_WIDTH-1:0] out_b_q, out_b_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_sof_q, out_sof_d;
    logic                  out_eol_q, out_eol_d;
    logic                  out_eof_q, out_eof_d;

    always_comb begin
        out_valid_d = s2_valid_q;
        out_sof_d   = s2_sof_q;
        out_eol_d   = s2_eol_q;
        out_eof_d   = s2_eof_q;
        out_r_d     = s2_valid_q ? s2_r_q : out_r_q;
        out_g_d     = s2_valid_q ? g_avg  : out_g_q;
        out_b_d     = s2_valid_q ? s2_b_q : out_b_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q         <= '0;
            y_q         <= '0;
            phase_q     <= 2'b00;
            s1_valid_q  <= 1'b0;
            s1_cur_q    <= '0;
            s1_emit_q   <= 1'b0;
            s1_xodd_q   <= 1'b0;
            s1_yodd_q   <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            s1_phase_q  <= 2'b00;
            left_top_q  <= '0;
            left_bot_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_r_q      <= '0;
            s2_b_q      <= '0;
            s2_g1_q     <= '0;
            s2_g2_q     <= '0;
            s2_sof_q    <= 1'b0;
            s2_eol_q    <= 1'b0;
            s2_eof_q    <= 1'b0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            phase_q     <= phase_d;
            s1_valid_q  <= s1_valid_d;
            s1_cur_q    <= s1_cur_d;
            s1_emit_q   <= s1_emit_d;
            s1_xodd_q   <= s1_xodd_d;
            s1_yodd_q   <= s1_yodd_d;
            s1_sof_q    <= s1_sof_d;
            s1_eol_q    <= s1_eol_d;
            s1_eof_q    <= s1_eof_d;
            s1_phase_q  <= s1_phase_d;
            left_top_q  <= left_top_d;
            left_bot_q  <= left_bot_d;
            s2_valid_q  <= s2_valid_d;
            s2_r_q      <= s2_r_d;
            s2_b_q      <= s2_b_d;
            s2_g1_q     <= s2_g1_d;
            s2_g2_q     <= s2_g2_d;
            s2_sof_q    <= s2_sof_d;
            s2_eol_q    <= s2_eol_d;
            s2_eof_q    <= s2_eof_d;
            out_r_q     <= out_r_d;
            out_g_q     <= out_g_d;
            out_b_q     <= out_b_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
        end
    end

    assign oR     = out_r_q;
    assign oG     = out_g_q;
    assign oB     = out_b_q;
    assign oValid = out_valid_q;
    assign oSof   = out_sof_q;
    assign oEol   = out_eol_q;
    assign oEof   = out_eof_q;

endmodule

// File: tb/tb_demosaic_neighbor_stream.sv
// Directed bench for demosaic_neighbor_stream on a 4x3 frame whose samples
// are the raster index 0..11. A second 10-bit instance sees the same control
// with every sample at full scale.
module tb_demosaic_neighbor_stream;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          i_sof = 1'b0;
    logic [1:0]    i_pattern = 2'b00;
    logic [DW-1:0] o_r, o_g, o_b;
    logic          o_valid, o_sof, o_eol, o_eof;

    logic [9:0]    i_data10 = 10'h3FF;
    logic [9:0]    o_r10, o_g10, o_b10;
    logic          o_valid10, o_sof10, o_eol10, o_eof10;

    demosaic_neighbor_stream #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .iData(i_data), .iValid(i_valid), .iSof(i_sof),
        .iPattern(i_pattern), .oR(o_r), .oG(o_g), .oB(o_b), .oValid(o_valid),
        .oSof(o_sof), .oEol(o_eol), .oEof(o_eof)
    );

    demosaic_neighbor_stream #(.DATA_WIDTH(10), .WIDTH(W), .HEIGHT(H)) dut10 (
        .clk(clk), .reset(reset), .iData(i_data10), .iValid(i_valid), .iSof(i_sof),
        .iPattern(i_pattern), .oR(o_r10), .oG(o_g10), .oB(o_b10), .oValid(o_valid10),
        .oSof(o_sof10), .oEol(o_eol10), .oEof(o_eof10)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected output per clock edge, written when the sample is driven.
    logic          exp_v   [0:1023];
    logic          exp_sof [0:1023];
    logic          exp_eol [0:1023];
    logic          exp_eof [0:1023];
    logic [DW-1:0] exp_r   [0:1023];
    logic [DW-1:0] exp_g   [0:1023];
    logic [DW-1:0] exp_b   [0:1023];

    logic [DW-1:0] last_r = '0, last_g = '0, last_b = '0;
    logic [9:0]    last10 = '0;

    // Hand-computed windows for the 0..11 ramp, in output order.
    // Row 0: RGGB, row 1: BGGR, row 2: GRBG.
    int r_tab [0:2][0:5] = '{'{0, 2, 2, 8, 10, 10}, '{5, 5, 7, 5, 5, 7}, '{1, 1, 3, 9, 9, 11}};
    int b_tab [0:2][0:5] = '{'{5, 5, 7, 5, 5, 7}, '{0, 2, 2, 8, 10, 10}, '{4, 6, 6, 4, 6, 6}};
`ifdef DEMOSAIC_ROUND_EN
    int g_tab [0:5] = '{3, 4, 5, 7, 8, 9};
`else
    int g_tab [0:5] = '{2, 3, 4, 6, 7, 8};
`endif
    logic [1:0] pat_code [0:2] = '{2'b00, 2'b11, 2'b01};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic sof,
                        input logic [1:0] pat, input logic ev, input int er,
                        input int eg, input int eb, input logic es,
                        input logic eeol, input logic eeof);
        int idx;
        @(negedge clk);
        i_valid   = v;
        i_data    = d;
        i_sof     = sof;
        i_pattern = pat;
        idx = (cyc + 3) % 1024;
        exp_v[idx]   = ev;
        exp_r[idx]   = DW'(er);
        exp_g[idx]   = DW'(eg);
        exp_b[idx]   = DW'(eb);
        exp_sof[idx] = es;
        exp_eol[idx] = eeol;
        exp_eof[idx] = eeof;
        @(posedge clk);
        #1;
        idx = cyc % 1024;
        if (exp_v[idx]) begin
            last_r = exp_r[idx];
            last_g = exp_g[idx];
            last_b = exp_b[idx];
            last10 = 10'h3FF;
        end
        check("oValid", 16'(o_valid), 16'(exp_v[idx]));
        check("oR", 16'(o_r), 16'(last_r));
        check("oG", 16'(o_g), 16'(last_g));
        check("oB", 16'(o_b), 16'(last_b));
        check("oSof", 16'(o_sof), 16'(exp_sof[idx]));
        check("oEol", 16'(o_eol), 16'(exp_eol[idx]));
        check("oEof", 16'(o_eof), 16'(exp_eof[idx]));
        check("dw10_oValid", 16'(o_valid10), 16'(exp_v[idx]));
        check("dw10_oR", 16'(o_r10), 16'(last10));
        check("dw10_oG", 16'(o_g10), 16'(last10));
        check("dw10_oB", 16'(o_b10), 16'(last10));
    endtask

    task automatic idle();
        step(1'b0, DW'($urandom), 1'($urandom), 2'($urandom), 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // pi selects the pattern row; n samples of the ramp are sent.
    task automatic send_frame(input int pi, input int n, input logic use_sof, input logic gaps);
        int k;
        logic [1:0] pat;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle();
            case (i)
                5:       k = 0;
                6:       k = 1;
                7:       k = 2;
                9:       k = 3;
                10:      k = 4;
                11:      k = 5;
                default: k = -1;
            endcase
            // Pattern is only meaningful on the origin sample; scramble it elsewhere.
            pat = (i == 0) ? pat_code[pi] : 2'($urandom);
            if (k >= 0)
                step(1'b1, DW'(i), use_sof && (i == 0), pat, 1'b1, r_tab[pi][k], g_tab[k],
                     b_tab[pi][k], k == 0, (k == 2) || (k == 5), k == 5);
            else
                step(1'b1, DW'(i), use_sof && (i == 0), pat, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic clear_expected();
        for (int i = 0; i < 1024; i++) begin
            exp_v[i]   = 1'b0;
            exp_sof[i] = 1'b0;
            exp_eol[i] = 1'b0;
            exp_eof[i] = 1'b0;
            exp_r[i]   = '0;
            exp_g[i]   = '0;
            exp_b[i]   = '0;
        end
        last_r = '0;
        last_g = '0;
        last_b = '0;
        last10 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_expected();
        #1 reset = 1'b0;
        #1;
        check("rst_oValid", 16'(o_valid), 16'd0);
        check("rst_oR", 16'(o_r), 16'd0);
        check("rst_oG", 16'(o_g), 16'd0);
        check("rst_oB", 16'(o_b), 16'd0);
        check("rst_oSof", 16'(o_sof), 16'd0);
        check("rst_oEof", 16'(o_eof), 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        send_frame(0, 12, 1'b1, 1'b0);     // RGGB, continuous
        send_frame(1, 12, 1'b1, 1'b0);     // BGGR, back-to-back
        send_frame(2, 12, 1'b1, 1'b1);     // GRBG, random gaps
        repeat (3) idle();
        send_frame(0, 7, 1'b1, 1'b0);      // aborted after sample 6
        send_frame(1, 12, 1'b1, 1'b0);     // iSof on the old frame's sample 7
        repeat (3) idle();

        // Reset while the first window of a frame is on the outputs.
        send_frame(0, 7, 1'b1, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        #3;
        check("pre_rst_oValid", 16'(o_valid), 16'd1);
        check("pre_rst_oB", 16'(o_b), 16'd5);
        check("pre_rst_oSof", 16'(o_sof), 16'd1);
        reset = 1'b0;
        #1;
        check("async_rst_oValid", 16'(o_valid), 16'd0);
        check("async_rst_oR", 16'(o_r), 16'd0);
        check("async_rst_oG", 16'(o_g), 16'd0);
        check("async_rst_oB", 16'(o_b), 16'd0);
        check("async_rst_oSof", 16'(o_sof), 16'd0);
        check("async_rst_dw10_oR", 16'(o_r10), 16'd0);
        clear_expected();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        send_frame(2, 12, 1'b0, 1'b1);     // no iSof: counters restart at (0,0)
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
